// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: shares one iterative Newton square-root unit between two
// requesters (port 0: FP pipeline issue, port 1: microcode/exception replay).
// Round-robin arbitration, operand hold for the whole operation, busy-window
// tracking with timeout, flush/kill, and a valid/ready result port.
module fsqrt_issue_ctrl #(
  parameter int unsigned RES_DLY = 1,   // cycles from busy fall to valid sq_s (0..7)
  parameter int unsigned TMO     = 63   // max cycles waiting for busy rise (1..255)
) (
  input  logic        clk,
  input  logic        clrn,
  // requesters
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_d0,
  input  logic [31:0] req_d1,
  input  logic [1:0]  req_rm0,
  input  logic [1:0]  req_rm1,
  output logic [1:0]  req_ready,
  // result port
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_s,
  output logic        res_tag,
  // control / status
  input  logic        flush,
  output logic        err_tmo,
  // square-root unit
  output logic [31:0] sq_d,
  output logic [1:0]  sq_rm,
  output logic        sq_fsqrt,
  output logic        sq_ena,
  input  logic [31:0] sq_s,
  input  logic        sq_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [7:0] TMO_C = 8'(TMO);
  localparam logic [2:0] DLY_C = 3'(RES_DLY);

  logic [2:0] state;
  logic       rr_ptr;     // port favoured in the next arbitration
  logic       op_tag;     // port id of the op in flight
  logic       kill;       // in-flight op was flushed; drop its result
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_nxt;
  logic [2:0] dly_cnt;

  logic       any_req;
  logic       win;
  logic       accept;
  logic       kill_now;

  // Arbitration: favoured port if it requests, otherwise the other one.
  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    any_req   = |req_valid;
    win       = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    req_ready = 2'b00;
    if (clrn && (state == S_IDLE) && any_req)
      req_ready = win ? 2'b10 : 2'b01;
    accept    = |(req_valid & req_ready);
    // a flush arriving in the capture cycle still discards the result
    kill_now  = kill | flush;
    tmo_nxt   = tmo_cnt + 8'd1;
  end

  // Issue FSM, operand/result registers and sticky timeout flag.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      op_tag    <= 1'b0;
      kill      <= 1'b0;
      tmo_cnt   <= 8'd0;
      dly_cnt   <= 3'd0;
      res_valid <= 1'b0;
      res_s     <= 32'd0;
      res_tag   <= 1'b0;
      err_tmo   <= 1'b0;
      sq_d      <= 32'd0;
      sq_rm     <= 2'b00;
      sq_fsqrt  <= 1'b0;
      sq_ena    <= 1'b0;
    end else begin
      sq_ena   <= 1'b1;
      sq_fsqrt <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // operand only changes here, so the unit always re-samples it unchanged
            sq_d     <= win ? req_d1  : req_d0;
            sq_rm    <= win ? req_rm1 : req_rm0;
            op_tag   <= win;
            rr_ptr   <= ~win;
            kill     <= 1'b0;
            sq_fsqrt <= 1'b1;          // high for exactly the ISSUE cycle
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= 8'd0;
          kill    <= kill_now;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          kill <= kill_now;
          if (sq_busy) begin
            state <= S_WAIT_DONE;
          end else if (tmo_nxt >= TMO_C) begin
            // unit never started: flag it and abandon the op without a result
            tmo_cnt <= TMO_C;
            err_tmo <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_nxt;
          end
        end
        S_WAIT_DONE: begin
          kill <= kill_now;
          if (!sq_busy) begin
            if (DLY_C == 3'd0) begin
              if (kill_now) begin
                state <= S_IDLE;
              end else begin
                res_s     <= sq_s;
                res_tag   <= op_tag;
                res_valid <= 1'b1;
                state     <= S_DONE;
              end
            end else begin
              dly_cnt <= DLY_C;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          kill <= kill_now;
          if (dly_cnt == 3'd0) begin
            if (kill_now) begin
              state <= S_IDLE;
            end else begin
              res_s     <= sq_s;
              res_tag   <= op_tag;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            dly_cnt <= dly_cnt - 3'd1;
          end
        end
        S_DONE: begin
          // a presented result is never retracted; flush has no effect here
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Self-checking bench for fsqrt_issue_ctrl with a behavioural sqrt unit model.
module tb_fsqrt_issue_ctrl;
  localparam int TMO     = 63;
  localparam int RES_DLY = 1;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  req_valid;
  logic [31:0] req_d0, req_d1;
  logic [1:0]  req_rm0, req_rm1;
  logic [1:0]  req_ready;
  logic        res_valid, res_ready;
  logic [31:0] res_s;
  logic        res_tag;
  logic        flush, err_tmo;
  logic [31:0] sq_d;
  logic [1:0]  sq_rm;
  logic        sq_fsqrt, sq_ena;
  logic [31:0] sq_s = 32'd0;
  logic        sq_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fsqrt_issue_ctrl #(.RES_DLY(RES_DLY), .TMO(TMO)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_d0(req_d0), .req_d1(req_d1),
    .req_rm0(req_rm0), .req_rm1(req_rm1), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_tag(res_tag),
    .flush(flush), .err_tmo(err_tmo),
    .sq_d(sq_d), .sq_rm(sq_rm), .sq_fsqrt(sq_fsqrt), .sq_ena(sq_ena),
    .sq_s(sq_s), .sq_busy(sq_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference square roots for the operands used here.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;  // sqrt(4) = 2
      32'h40000000: return 32'h3FB504F3;  // sqrt(2)
      32'h3F800000: return 32'h3F800000;  // sqrt(1) = 1
      default:      return 32'h7FC00000;  // NaN for negatives
    endcase
  endfunction

  // Unit model: busy rises the edge after the start pulse, stays high for
  // busy_len cycles, result valid from the falling edge of busy.
  int          busy_len  = 4;
  logic        unit_dead = 1'b0;
  int          bcnt      = 0;
  logic [31:0] op        = 32'd0;
  always @(posedge clk) begin
    if (!clrn) begin
      sq_busy <= 1'b0;
      bcnt    <= 0;
    end else if (sq_fsqrt && !unit_dead) begin
      sq_busy <= 1'b1;
      bcnt    <= busy_len - 1;
      op      <= sq_d;
    end else if (sq_busy) begin
      if (bcnt == 0) begin
        sq_busy <= 1'b0;
        sq_s    <= ref_sqrt(op);
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // Wait (bounded) for res_valid, check the result, then complete the handshake.
  task automatic finish_op(input string name, input logic [31:0] exp_s, input logic exp_tag);
    int k = 0;
    while (res_valid !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, " res_valid seen"}, {31'd0, res_valid}, 32'd1);
    check({name, " res_s"}, res_s, exp_s);
    check({name, " res_tag"}, {31'd0, res_tag}, {31'd0, exp_tag});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " res_valid drop"}, {31'd0, res_valid}, 32'd0);
  endtask

  // Wait (bounded) for any grant; returns at a negedge +1 with req_ready settled.
  task automatic wait_grant(input string name, output logic [1:0] g);
    int k = 0;
    #1;
    while (req_ready == 2'b00 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    g = req_ready;
    check({name, " grant seen"}, {31'd0, (g != 2'b00)}, 32'd1);
  endtask

  // One single-port operation with latency and operand-stability checks.
  task automatic run_op(input string name, input int p, input logic [31:0] d,
                        input logic [1:0] rm, input int blen, input logic [31:0] exp_s);
    int  lat;
    int  fs_cnt;
    bit  stable;
    busy_len = blen;
    @(negedge clk);
    if (p == 1) begin req_d1 = d; req_rm1 = rm; req_valid = 2'b10; end
    else        begin req_d0 = d; req_rm0 = rm; req_valid = 2'b01; end
    #1 check({name, " grant"}, {30'd0, req_ready}, (p == 1) ? 32'd2 : 32'd1);
    @(negedge clk);                 // accept edge has passed: ISSUE cycle
    req_valid = 2'b00;
    check({name, " sq_fsqrt"}, {31'd0, sq_fsqrt}, 32'd1);
    check({name, " sq_ena"}, {31'd0, sq_ena}, 32'd1);
    check({name, " sq_d"}, sq_d, d);
    check({name, " sq_rm"}, {30'd0, sq_rm}, {30'd0, rm});
    lat = 0; fs_cnt = 1; stable = 1'b1;
    while (res_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (sq_fsqrt) fs_cnt++;
      if (sq_d !== d || sq_rm !== rm) stable = 1'b0;
    end
    check({name, " latency"}, lat, blen + RES_DLY + 3);
    check({name, " fsqrt pulses"}, fs_cnt, 1);
    check({name, " operand stable"}, {31'd0, stable}, 32'd1);
    finish_op(name, exp_s, (p == 1));
  endtask

  typedef struct {
    string       name;
    int          port;
    logic [31:0] d;
    logic [1:0]  rm;
    int          blen;
    logic [31:0] exp_s;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [1:0]  g;
    logic [31:0] held_s;
    logic        held_tag;
    bit          ok;
    logic [1:0]  exp_g[4];
    logic [31:0] exp_s_alt[4];

    vecs[0] = '{"v0 sqrt4 p0",  0, 32'h40800000, 2'b00, 26, 32'h40000000};
    vecs[1] = '{"v1 sqrt1 p1",  1, 32'h3F800000, 2'b10, 5,  32'h3F800000};
    vecs[2] = '{"v2 sqrt2 b1",  0, 32'h40000000, 2'b01, 1,  32'h3FB504F3};
    vecs[3] = '{"v3 sqrt4 p1",  1, 32'h40800000, 2'b11, 12, 32'h40000000};

    clrn = 1'b0; req_valid = 2'b00; req_d0 = 32'd0; req_d1 = 32'd0;
    req_rm0 = 2'b00; req_rm1 = 2'b00; res_ready = 1'b0; flush = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst res_valid", {31'd0, res_valid}, 32'd0);
    check("rst res_s", res_s, 32'd0);
    check("rst sq_ena", {31'd0, sq_ena}, 32'd0);
    check("rst sq_fsqrt", {31'd0, sq_fsqrt}, 32'd0);
    check("rst err_tmo", {31'd0, err_tmo}, 32'd0);
    check("rst sq_d", sq_d, 32'd0);
    clrn = 1'b1;
    @(negedge clk);
    #1 check("idle no req ready", {30'd0, req_ready}, 32'd0);

    // table-driven single operations
    for (int i = 0; i < 4; i++)
      run_op(vecs[i].name, vecs[i].port, vecs[i].d, vecs[i].rm, vecs[i].blen, vecs[i].exp_s);

    // consumer stall: result held, no accepts, accept resumes right after handshake
    busy_len = 6;
    @(negedge clk);
    req_d0 = 32'h40000000; req_valid = 2'b01;
    wait_grant("stall p0", g);
    @(negedge clk);
    req_d1 = 32'h3F800000; req_valid = 2'b10;
    while (res_valid !== 1'b1 && n_cmp < 100000) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
    end
    held_s = res_s; held_tag = res_tag; ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (res_valid !== 1'b1 || res_s !== held_s || res_tag !== held_tag || req_ready !== 2'b00)
        ok = 1'b0;
    end
    check("stall hold", {31'd0, ok}, 32'd1);
    check("stall res_s", held_s, 32'h3FB504F3);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1 check("stall resume ready", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    finish_op("stall p1", 32'h3F800000, 1'b1);

    // flush 5 cycles into busy: no result, next op normal
    busy_len = 26;
    @(negedge clk);
    req_d0 = 32'hC0800000; req_valid = 2'b01;
    wait_grant("flush p0", g);
    @(negedge clk);
    req_valid = 2'b00;
    check("flush sq_fsqrt", {31'd0, sq_fsqrt}, 32'd1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) ok = 1'b0;
    end
    check("flush no result", {31'd0, ok}, 32'd1);
    run_op("after flush", 0, 32'h3F800000, 2'b00, 4, 32'h3F800000);

    // busy timeout: unit never starts
    unit_dead = 1'b1;
    @(negedge clk);
    req_d1 = 32'h40800000; req_valid = 2'b10;
    wait_grant("tmo p1", g);
    @(negedge clk);
    req_valid = 2'b00;
    check("tmo sq_fsqrt", {31'd0, sq_fsqrt}, 32'd1);
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge clk);
      if (i == TMO)     check("tmo err early", {31'd0, err_tmo}, 32'd0);
      if (i == TMO + 1) check("tmo err set", {31'd0, err_tmo}, 32'd1);
    end
    check("tmo no result", {31'd0, res_valid}, 32'd0);
    unit_dead = 1'b0;
    run_op("after tmo", 1, 32'h40800000, 2'b00, 3, 32'h40000000);
    check("tmo sticky", {31'd0, err_tmo}, 32'd1);

    // reset pulse during WAIT_DONE
    busy_len = 26;
    @(negedge clk);
    req_d0 = 32'h40800000; req_valid = 2'b01;
    wait_grant("rst-mid p0", g);
    @(negedge clk);
    repeat (10) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid req_ready", {30'd0, req_ready}, 32'd0);
    check("rstmid res_valid", {31'd0, res_valid}, 32'd0);
    check("rstmid res_s", res_s, 32'd0);
    check("rstmid res_tag", {31'd0, res_tag}, 32'd0);
    check("rstmid err_tmo", {31'd0, err_tmo}, 32'd0);
    check("rstmid sq_d", sq_d, 32'd0);
    check("rstmid sq_rm", {30'd0, sq_rm}, 32'd0);
    check("rstmid sq_fsqrt", {31'd0, sq_fsqrt}, 32'd0);
    check("rstmid sq_ena", {31'd0, sq_ena}, 32'd0);
    req_valid = 2'b00;
    clrn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) ok = 1'b0;
    end
    check("rstmid no result", {31'd0, ok}, 32'd1);

    // both ports continuously valid: grants alternate starting with port 0
    busy_len = 3;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_s_alt[0] = 32'h3FB504F3; exp_s_alt[1] = 32'h40000000;
    exp_s_alt[2] = 32'h3FB504F3; exp_s_alt[3] = 32'h40000000;
    @(negedge clk);
    req_d0 = 32'h40000000; req_d1 = 32'h40800000; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant("alt", g);
      check($sformatf("alt grant %0d", i), {30'd0, g}, {30'd0, exp_g[i]});
      @(negedge clk);
      finish_op($sformatf("alt op %0d", i), exp_s_alt[i], exp_g[i][1]);
    end
    req_valid = 2'b00;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
